// File: rtl/sha256_digest_collector.sv
// ============================================================================
// sha256_digest_collector : packs a byte-serial SHA-256 digest into 8 words,
// flags completion / gap timeout; SHA_DIGEST_CMP_EN enables expected compare.
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_digest_collector #(
  parameter int unsigned GAP_LIMIT = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [7:0]  hash_byte_in,
  input  logic        hash_valid_in,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        exp_wr_en,
  input  logic [2:0]  exp_wr_addr,
  input  logic [31:0] exp_wr_data,
  output logic        busy,
  output logic        digest_done,
  output logic        match,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(GAP_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             timeout_q, timeout_d;
  logic             match_q, match_d;
  logic [31:0]      words_q [8];

  logic             w_store;
  logic [4:0]       w_idx;
  logic             w_cmp_eq;
  logic [CNT_W-1:0] w_gap_inc;

  assign w_gap_inc = gap_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      timeout_q  <= timeout_d;
      match_q    <= match_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout_d  = timeout_q;
    match_d    = match_q;
    w_store    = 1'b0;
    w_idx      = byte_cnt_q[4:0];
    if (clear) begin
      state_d    = S_IDLE;
      byte_cnt_d = '0;
      gap_cnt_d  = '0;
      timeout_d  = 1'b0;
      match_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (hash_valid_in) begin
            state_d    = S_COLLECT;
            w_store    = 1'b1;
            w_idx      = 5'd0;
            byte_cnt_d = 6'd1;
            gap_cnt_d  = '0;
            match_d    = 1'b0;
          end
        end
        S_COLLECT: begin
          if (hash_valid_in) begin
            w_store    = 1'b1;
            byte_cnt_d = byte_cnt_q + 6'd1;
            gap_cnt_d  = '0;
            if (byte_cnt_q == 6'd31) state_d = S_CHECK;
          end else if (w_gap_inc == GAP_MAX) begin
            // Stalled stream: abandon the partial digest
            state_d    = S_IDLE;
            byte_cnt_d = '0;
            gap_cnt_d  = '0;
            timeout_d  = 1'b1;
          end else begin
            gap_cnt_d  = w_gap_inc;
          end
        end
        S_CHECK: begin
          state_d = S_DONE;
          match_d = w_cmp_eq;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Byte k lands in word k/4, most significant byte first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) words_q[i] <= '0;
    end else if (w_store) begin
      unique case (w_idx[1:0])
        2'd0: words_q[w_idx[4:2]][31:24] <= hash_byte_in;
        2'd1: words_q[w_idx[4:2]][23:16] <= hash_byte_in;
        2'd2: words_q[w_idx[4:2]][15:8]  <= hash_byte_in;
        default: words_q[w_idx[4:2]][7:0] <= hash_byte_in;
      endcase
    end
  end

`ifdef SHA_DIGEST_CMP_EN
  logic [31:0] exp_q [8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) exp_q[i] <= '0;
    end else if (exp_wr_en) begin
      exp_q[exp_wr_addr] <= exp_wr_data;
    end
  end

  always_comb begin
    w_cmp_eq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (words_q[i] != exp_q[i]) w_cmp_eq = 1'b0;
    end
  end
`else
  logic w_unused_exp;
  assign w_unused_exp = ^{exp_wr_en, exp_wr_addr, exp_wr_data};
  assign w_cmp_eq     = 1'b0;
`endif

  assign rd_data     = words_q[rd_addr];
  assign busy        = (state_q == S_COLLECT) || (state_q == S_CHECK);
  assign digest_done = (state_q == S_DONE);
  assign match       = match_q;
  assign timeout_err = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_digest_collector.sv
// Directed bench for sha256_digest_collector: "abc" digest, compare, timeout,
// clear and asynchronous reset scenarios.
`default_nettype none

module tb_sha256_digest_collector;

`ifdef SHA_DIGEST_CMP_EN
  localparam logic [31:0] CMP = 32'd1;
`else
  localparam logic [31:0] CMP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  hash_byte_in = 8'h00;
  logic        hash_valid_in = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] rd_data;
  logic        exp_wr_en = 1'b0;
  logic [2:0]  exp_wr_addr = 3'd0;
  logic [31:0] exp_wr_data = 32'h0;
  logic        busy, digest_done, match, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] abc_w [8];
  logic [31:0] exp_w [8];
  logic [7:0]  stim  [32];

  sha256_digest_collector #(.GAP_LIMIT(16), .CNT_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .hash_byte_in (hash_byte_in),
    .hash_valid_in(hash_valid_in),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .exp_wr_en    (exp_wr_en),
    .exp_wr_addr  (exp_wr_addr),
    .exp_wr_data  (exp_wr_data),
    .busy         (busy),
    .digest_done  (digest_done),
    .match        (match),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 8; i++) begin
      exp_w[i] = abc_w[i];
      for (int j = 0; j < 4; j++) stim[4*i+j] = abc_w[i][31-8*j -: 8];
    end
  endtask

  task automatic send_from(input int start, input int gap);
    for (int k = start; k < 32; k++) begin
      hash_valid_in = 1'b1;
      hash_byte_in  = stim[k];
      tick();
      hash_valid_in = 1'b0;
      if (k != 31) repeat (gap) tick();
    end
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) begin
      hash_valid_in = 1'b1;
      hash_byte_in  = stim[k];
      tick();
    end
    hash_valid_in = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_chk_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_chk_done"}, {31'd0, digest_done}, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, digest_done}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk($sformatf("%s_w%0d", tag, i), rd_data, exp_w[i]);
    end
    rd_addr = 3'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    abc_w[0] = 32'hba7816bf; abc_w[1] = 32'h8f01cfea;
    abc_w[2] = 32'h414140de; abc_w[3] = 32'h5dae2223;
    abc_w[4] = 32'hb00361a3; abc_w[5] = 32'h96177a9c;
    abc_w[6] = 32'hb410ff61; abc_w[7] = 32'hf20015ad;

    // Reset state
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, digest_done}, 32'd0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // T1: "abc" digest, back-to-back bytes
    load_abc();
    send_from(0, 0);
    check_done("t1");
    check_words("t1");

    // T2: program expected value, stream again, then corrupt byte 5
    for (int i = 0; i < 8; i++) begin
      exp_wr_en = 1'b1; exp_wr_addr = 3'(i); exp_wr_data = abc_w[i];
      tick();
    end
    exp_wr_en = 1'b0;
    hash_valid_in = 1'b1; hash_byte_in = stim[0];
    tick();
    hash_valid_in = 1'b0;
    chk("t2_restart_done", {31'd0, digest_done}, 32'd0);
    chk("t2_restart_busy", {31'd0, busy}, 32'd1);
    send_from(1, 0);
    check_done("t2a");
    chk("t2a_match", {31'd0, match}, CMP);
    stim[5] = 8'hce;
    exp_w[1] = 32'h8fcecfea;
    send_from(0, 0);
    check_done("t2b");
    chk("t2b_match", {31'd0, match}, 32'd0);
    check_words("t2b");

    // T3: stall after 10 bytes
    load_abc();
    send_partial(10);
    repeat (15) tick();
    chk("t3_pre_tmo", {31'd0, timeout_err}, 32'd0);
    chk("t3_pre_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t3_tmo", {31'd0, timeout_err}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_done", {31'd0, digest_done}, 32'd0);
    send_from(0, 0);
    check_done("t3");
    check_words("t3");
    chk("t3_tmo_sticky", {31'd0, timeout_err}, 32'd1);
    do_clear();
    chk("t3_clr_tmo", {31'd0, timeout_err}, 32'd0);
    chk("t3_clr_done", {31'd0, digest_done}, 32'd0);

    // T4: 15-cycle gaps between every byte
    for (int k = 0; k < 32; k++) stim[k] = 8'(k * 37 + 11);
    for (int i = 0; i < 8; i++) exp_w[i] = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
    send_from(0, 15);
    chk("t4_tmo", {31'd0, timeout_err}, 32'd0);
    check_done("t4");
    check_words("t4");

    // T5: clear with valid high at byte 20
    load_abc();
    send_partial(20);
    hash_valid_in = 1'b1; hash_byte_in = 8'h5a; clear = 1'b1;
    tick();
    hash_valid_in = 1'b0; clear = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    send_from(0, 0);
    check_done("t5");
    check_words("t5");

    // T6: asynchronous reset in the middle of a digest
    send_partial(12);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, digest_done}, 32'd0);
    chk("t6_match", {31'd0, match}, 32'd0);
    chk("t6_rd", rd_data, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    send_from(0, 0);
    check_done("t6");
    check_words("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
